// File: rtl/input_ctrl_if.sv
// Control bundle between the host core and input_ctrl: raw PS/2 and joystick
// inputs in, merged per-player controls and service buttons out.
interface input_ctrl_if #(
    parameter int PLAYERS = 2,
    parameter int BUTTONS = 3
);
    logic [10:0]                    ps2_key;
    logic [32*PLAYERS-1:0]          joystick;
    logic [PLAYERS*BUTTONS-1:0]     autofire_en;
    logic                           clear;
    logic [(BUTTONS+7)*PLAYERS-1:0] player;
    logic [1:0]                     service;

    modport master (
        output ps2_key, joystick, autofire_en, clear,
        input  player, service
    );

    modport slave (
        input  ps2_key, joystick, autofire_en, clear,
        output player, service
    );
endinterface

// File: rtl/input_ctrl.sv
// input_ctrl: merges PS/2 key latches with per-player joystick bits, turns
// the merged coin into a fixed-length pulse and gates autofire buttons.
module input_ctrl #(
    parameter int PLAYERS     = 2,
    parameter int BUTTONS     = 3,
    parameter int COIN_CYCLES = 16,
    parameter int AF_PERIOD   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input_ctrl_if.slave bus
);
    localparam int PW    = BUTTONS + 7;
    localparam int CW    = (COIN_CYCLES > 1) ? $clog2(COIN_CYCLES) : 1;
    localparam int AW    = (AF_PERIOD > 1) ? $clog2(AF_PERIOD) : 1;
    localparam int NKEYS = 21;

    typedef enum logic [4:0] {
        K_P1_R, K_P1_L, K_P1_D, K_P1_U, K_P1_F1, K_P1_F2, K_P1_F3,
        K_P1_START, K_P1_COIN, K_P1_PAUSE,
        K_P2_R, K_P2_L, K_P2_D, K_P2_U, K_P2_F1, K_P2_F2, K_P2_F3,
        K_P2_START, K_P2_COIN,
        K_SVC1, K_SVC2
    } key_e;

    logic                       toggle_q;
    logic                       armed_q;
    logic [NKEYS-1:0]           key_q, key_d;
    logic                       key_event;
    logic                       key_hit;
    key_e                       key_idx;
    logic [PLAYERS-1:0]         coin_active_q, coin_active_d;
    logic [PLAYERS-1:0]         coin_prev_q, coin_prev_d;
    logic [PLAYERS-1:0][CW-1:0] coin_cnt_q, coin_cnt_d;
    logic [AW-1:0]              af_cnt_q;
    logic                       af_phase_q;
    logic [PW*PLAYERS-1:0]      player_q, player_d;
    logic [1:0]                 service_q;
    logic                       unused_bits;

    // Map the scancode to a key latch; P1 directions need the E0 prefix, P2/service keys must lack it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        key_hit   = 1'b1;
        key_idx   = K_P1_R;
        key_event = armed_q && (bus.ps2_key[10] != toggle_q);
        if (bus.ps2_key[8]) begin
            case (bus.ps2_key[7:0])
                8'h75:   key_idx = K_P1_U;
                8'h72:   key_idx = K_P1_D;
                8'h6B:   key_idx = K_P1_L;
                8'h74:   key_idx = K_P1_R;
                8'h14:   key_idx = K_P1_F1;
                8'h11:   key_idx = K_P1_F2;
                8'h29:   key_idx = K_P1_F3;
                8'h16:   key_idx = K_P1_START;
                8'h2E:   key_idx = K_P1_COIN;
                8'h4D:   key_idx = K_P1_PAUSE;
                default: key_hit = 1'b0;
            endcase
        end else begin
            case (bus.ps2_key[7:0])
                8'h14:   key_idx = K_P1_F1;
                8'h11:   key_idx = K_P1_F2;
                8'h29:   key_idx = K_P1_F3;
                8'h16:   key_idx = K_P1_START;
                8'h2E:   key_idx = K_P1_COIN;
                8'h4D:   key_idx = K_P1_PAUSE;
                8'h2D:   key_idx = K_P2_U;
                8'h2B:   key_idx = K_P2_D;
                8'h23:   key_idx = K_P2_L;
                8'h34:   key_idx = K_P2_R;
                8'h1C:   key_idx = K_P2_F1;
                8'h1B:   key_idx = K_P2_F2;
                8'h15:   key_idx = K_P2_F3;
                8'h1E:   key_idx = K_P2_START;
                8'h36:   key_idx = K_P2_COIN;
                8'h46:   key_idx = K_SVC1;
                8'h45:   key_idx = K_SVC2;
                default: key_hit = 1'b0;
            endcase
        end
    end

    // Next key latch state: clear dominates and swallows a simultaneous event.
    always_comb begin
        key_d = key_q;
        if (bus.clear) begin
            key_d = '0;
        end else if (key_event && key_hit) begin
            key_d[key_idx] = bus.ps2_key[9];
        end
    end

    // Merge keys with joystick, run the coin pulse timers and apply autofire gating.
    always_comb begin
        logic [PW-1:0] kv;
        logic [PW-1:0] merged;
        logic [PW-1:0] out;
        player_d      = '0;
        coin_active_d = coin_active_q;
        coin_cnt_d    = coin_cnt_q;
        coin_prev_d   = coin_prev_q;
        for (int p = 0; p < PLAYERS; p++) begin
            kv = '0;
            if (p == 0) begin
                kv[0]         = key_q[K_P1_R];
                kv[1]         = key_q[K_P1_L];
                kv[2]         = key_q[K_P1_D];
                kv[3]         = key_q[K_P1_U];
                kv[4+BUTTONS] = key_q[K_P1_START];
                kv[5+BUTTONS] = key_q[K_P1_COIN];
                kv[6+BUTTONS] = key_q[K_P1_PAUSE];
                for (int b = 0; b < BUTTONS && b < 3; b++) begin
                    kv[4+b] = key_q[K_P1_F1+b];
                end
            end else if (p == 1) begin
                kv[0]         = key_q[K_P2_R];
                kv[1]         = key_q[K_P2_L];
                kv[2]         = key_q[K_P2_D];
                kv[3]         = key_q[K_P2_U];
                kv[4+BUTTONS] = key_q[K_P2_START];
                kv[5+BUTTONS] = key_q[K_P2_COIN];
                for (int b = 0; b < BUTTONS && b < 3; b++) begin
                    kv[4+b] = key_q[K_P2_F1+b];
                end
            end
            merged = kv | bus.joystick[p*32 +: PW];

            if (coin_active_q[p]) begin
                if (coin_cnt_q[p] == CW'(COIN_CYCLES - 1)) begin
                    coin_active_d[p] = 1'b0;
                    coin_cnt_d[p]    = '0;
                end else begin
                    coin_cnt_d[p] = coin_cnt_q[p] + 1'b1;
                end
            end else if (merged[5+BUTTONS] && !coin_prev_q[p]) begin
                coin_active_d[p] = 1'b1;
                coin_cnt_d[p]    = '0;
            end
            coin_prev_d[p] = merged[5+BUTTONS];

            out = merged;
            for (int b = 0; b < BUTTONS; b++) begin
                if (bus.autofire_en[p*BUTTONS+b]) begin
                    out[4+b] = merged[4+b] & af_phase_q;
                end
            end
            out[5+BUTTONS]        = coin_active_d[p];
            player_d[p*PW +: PW] = out;
        end
    end

    // PS/2 toggle tracking and key latches; the first sample after reset only arms the detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_q <= 1'b0;
            armed_q  <= 1'b0;
            key_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            toggle_q <= bus.ps2_key[10];
            armed_q  <= 1'b1;
            key_q    <= key_d;
        end
    end

    // Free-running autofire divider; the phase flips each time the counter wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            af_cnt_q   <= '0;
            af_phase_q <= 1'b1;
        end else if (af_cnt_q == AW'(AF_PERIOD - 1)) begin
            af_cnt_q   <= '0;
            af_phase_q <= ~af_phase_q;
        end else begin
            af_cnt_q <= af_cnt_q + 1'b1;
        end
    end

    // Registered outputs and coin pulse state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coin_active_q <= '0;
            coin_cnt_q    <= '0;
            coin_prev_q   <= '0;
            player_q      <= '0;
            service_q     <= '0;
        end else begin
            coin_active_q <= coin_active_d;
            coin_cnt_q    <= coin_cnt_d;
            coin_prev_q   <= coin_prev_d;
            player_q      <= player_d;
            service_q     <= {key_q[K_SVC2], key_q[K_SVC1]};
        end
    end

    assign bus.player  = player_q;
    assign bus.service = service_q;

    // Joystick bits above each player's slice and P2 latches with PLAYERS=1 are intentionally dropped.
    assign unused_bits = ^{bus.joystick, key_q};
endmodule

// File: tb/tb_input_ctrl.sv
// Directed bench for input_ctrl: a 2-player/3-button instance for most
// features plus a 4-player/6-button instance for the wide bit layout.
module tb_input_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    input_ctrl_if #(.PLAYERS(2), .BUTTONS(3)) bus ();
    input_ctrl_if #(.PLAYERS(4), .BUTTONS(6)) bus4 ();

    input_ctrl #(.PLAYERS(2), .BUTTONS(3), .COIN_CYCLES(16), .AF_PERIOD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    input_ctrl #(.PLAYERS(4), .BUTTONS(6), .COIN_CYCLES(16), .AF_PERIOD(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    always #5 clk = ~clk;

    // Advance n clock cycles and land on the falling edge for sampling/driving.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
        bus.ps2_key = {~bus.ps2_key[10], pressed, ext, code};
    endtask

    task automatic send_key4(input logic pressed, input logic ext, input logic [7:0] code);
        bus4.ps2_key = {~bus4.ps2_key[10], pressed, ext, code};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        step(2);
        checks++; if (bus.player !== 20'h0) begin failures++; $display("FAIL rst_player: got=%h exp=%h", bus.player, 20'h0); end
        checks++; if (bus.service !== 2'b00) begin failures++; $display("FAIL rst_service: got=%b exp=%b", bus.service, 2'b00); end
        checks++; if (bus4.player !== 52'h0) begin failures++; $display("FAIL rst_player4: got=%h exp=%h", bus4.player, 52'h0); end
        // ps2_key[10] is 1 with a pressed E0 75 pending; releasing reset must not see an event
        rst_n = 1'b1;
        step(3);
        checks++; if (bus.player !== 20'h0) begin failures++; $display("FAIL rst_first_capture: got=%h exp=%h", bus.player, 20'h0); end
    endtask

    task automatic test_ext_key();
        send_key(1'b1, 1'b1, 8'h75);
        step(1);
        checks++; if (bus.player[3] !== 1'b0) begin failures++; $display("FAIL up_lat1: got=%b exp=%b", bus.player[3], 1'b0); end
        step(1);
        checks++; if (bus.player !== 20'h00008) begin failures++; $display("FAIL up_ext: got=%h exp=%h", bus.player, 20'h00008); end
        send_key(1'b0, 1'b1, 8'h75);
        step(2);
        checks++; if (bus.player !== 20'h0) begin failures++; $display("FAIL up_release: got=%h exp=%h", bus.player, 20'h0); end
        send_key(1'b1, 1'b0, 8'h75);
        step(2);
        checks++; if (bus.player !== 20'h0) begin failures++; $display("FAIL numpad_up: got=%h exp=%h", bus.player, 20'h0); end
        send_key(1'b0, 1'b0, 8'h75);
        step(1);
        send_key(1'b1, 1'b1, 8'h74);
        step(1);
        send_key(1'b1, 1'b1, 8'h14);
        step(2);
        checks++; if (bus.player !== 20'h00011) begin failures++; $display("FAIL right_fire1_ext: got=%h exp=%h", bus.player, 20'h00011); end
        send_key(1'b0, 1'b1, 8'h74);
        step(1);
        send_key(1'b0, 1'b0, 8'h14);
        step(2);
        checks++; if (bus.player !== 20'h0) begin failures++; $display("FAIL ext_release: got=%h exp=%h", bus.player, 20'h0); end
    endtask

    task automatic test_merge();
        bus.joystick[9:0] = 10'h225;
        bus.joystick[35]  = 1'b1;
        step(1);
        checks++; if (bus.player !== 20'h02225) begin failures++; $display("FAIL joy_merge: got=%h exp=%h", bus.player, 20'h02225); end
        send_key(1'b1, 1'b0, 8'h1C);
        step(2);
        checks++; if (bus.player !== 20'h06225) begin failures++; $display("FAIL key_p2_fire1: got=%h exp=%h", bus.player, 20'h06225); end
        send_key(1'b1, 1'b0, 8'h11);
        step(1);
        bus.joystick = '0;
        step(1);
        checks++; if (bus.player !== 20'h04020) begin failures++; $display("FAIL key_or_joy: got=%h exp=%h", bus.player, 20'h04020); end
        send_key(1'b1, 1'b0, 8'h46);
        step(2);
        checks++; if (bus.service !== 2'b01) begin failures++; $display("FAIL service1: got=%b exp=%b", bus.service, 2'b01); end
        send_key(1'b1, 1'b0, 8'h45);
        step(2);
        checks++; if (bus.service !== 2'b11) begin failures++; $display("FAIL service2: got=%b exp=%b", bus.service, 2'b11); end
        send_key(1'b0, 1'b0, 8'h46);
        step(1);
        send_key(1'b0, 1'b0, 8'h45);
        step(1);
        send_key(1'b0, 1'b0, 8'h1C);
        step(1);
        send_key(1'b0, 1'b0, 8'h11);
        step(2);
        checks++; if (bus.player !== 20'h0) begin failures++; $display("FAIL merge_release: got=%h exp=%h", bus.player, 20'h0); end
        checks++; if (bus.service !== 2'b00) begin failures++; $display("FAIL service_release: got=%b exp=%b", bus.service, 2'b00); end
    endtask

    task automatic test_coin();
        int   highs;
        int   rises;
        logic prev;
        logic cur;
        // coin held 40 cycles: one pulse of exactly 16
        highs = 0; rises = 0; prev = 1'b0;
        bus.joystick[8] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(1);
            cur = bus.player[8];
            if (i == 0) begin
                checks++; if (cur !== 1'b1) begin failures++; $display("FAIL coin_latency: got=%b exp=%b", cur, 1'b1); end
            end
            if (cur && !prev) rises++;
            if (cur) highs++;
            prev = cur;
        end
        checks++; if (highs !== 16) begin failures++; $display("FAIL coin_len: got=%0d exp=%0d", highs, 16); end
        checks++; if (rises !== 1) begin failures++; $display("FAIL coin_pulses: got=%0d exp=%0d", rises, 1); end
        bus.joystick[8] = 1'b0;
        step(2);
        // second rising edge lands on pulse cycle 8 and must not extend it
        highs = 0; rises = 0; prev = 1'b0;
        bus.joystick[8] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == 4) bus.joystick[8] = 1'b0;
            if (i == 7) bus.joystick[8] = 1'b1;
            step(1);
            cur = bus.player[8];
            if (cur && !prev) rises++;
            if (cur) highs++;
            prev = cur;
        end
        checks++; if (highs !== 16) begin failures++; $display("FAIL coin_noext_len: got=%0d exp=%0d", highs, 16); end
        checks++; if (rises !== 1) begin failures++; $display("FAIL coin_noext_pulses: got=%0d exp=%0d", rises, 1); end
        bus.joystick[8] = 1'b0;
        step(2);
        // coin from the keyboard arrives two cycles after the event
        send_key(1'b1, 1'b0, 8'h2E);
        step(1);
        checks++; if (bus.player[8] !== 1'b0) begin failures++; $display("FAIL key_coin_lat1: got=%b exp=%b", bus.player[8], 1'b0); end
        step(1);
        checks++; if (bus.player[8] !== 1'b1) begin failures++; $display("FAIL key_coin_lat2: got=%b exp=%b", bus.player[8], 1'b1); end
        send_key(1'b0, 1'b0, 8'h2E);
        step(20);
        checks++; if (bus.player[8] !== 1'b0) begin failures++; $display("FAIL key_coin_end: got=%b exp=%b", bus.player[8], 1'b0); end
    endtask

    task automatic test_clear();
        send_key(1'b1, 1'b0, 8'h14);
        step(1);
        send_key(1'b1, 1'b0, 8'h29);
        step(2);
        checks++; if (bus.player !== 20'h00050) begin failures++; $display("FAIL clear_setup: got=%h exp=%h", bus.player, 20'h00050); end
        send_key(1'b0, 1'b0, 8'h14);
        bus.clear = 1'b1;
        step(1);
        bus.clear = 1'b0;
        checks++; if (bus.player !== 20'h00050) begin failures++; $display("FAIL clear_lat1: got=%h exp=%h", bus.player, 20'h00050); end
        step(1);
        checks++; if (bus.player !== 20'h0) begin failures++; $display("FAIL clear_lat2: got=%h exp=%h", bus.player, 20'h0); end
        // a press coinciding with clear is consumed and never resurfaces
        send_key(1'b1, 1'b0, 8'h11);
        bus.clear = 1'b1;
        step(1);
        bus.clear = 1'b0;
        step(3);
        checks++; if (bus.player !== 20'h0) begin failures++; $display("FAIL clear_consumed: got=%h exp=%h", bus.player, 20'h0); end
    endtask

    task automatic test_autofire();
        logic [1:0] exp_af;
        bus.joystick       = '0;
        bus.joystick[4]    = 1'b1;
        bus.joystick[5]    = 1'b1;
        bus.autofire_en    = 6'b000001;
        do_reset();
        for (int n = 1; n <= 32; n++) begin
            step(1);
            exp_af = {1'b1, ((((n - 1) / 4) % 2) == 0)};
            checks++; if (bus.player[5:4] !== exp_af) begin failures++; $display("FAIL autofire_c%0d: got=%b exp=%b", n, bus.player[5:4], exp_af); end
        end
        bus.autofire_en = '0;
        bus.joystick    = '0;
        step(2);
    endtask

    task automatic test_reset_mid();
        send_key(1'b1, 1'b0, 8'h14);
        step(1);
        send_key(1'b1, 1'b0, 8'h46);
        step(2);
        bus.joystick[8] = 1'b1;
        step(3);
        checks++; if (bus.player !== 20'h00110) begin failures++; $display("FAIL mid_setup: got=%h exp=%h", bus.player, 20'h00110); end
        checks++; if (bus.service !== 2'b01) begin failures++; $display("FAIL mid_setup_svc: got=%b exp=%b", bus.service, 2'b01); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.player !== 20'h0) begin failures++; $display("FAIL async_player: got=%h exp=%h", bus.player, 20'h0); end
        checks++; if (bus.service !== 2'b00) begin failures++; $display("FAIL async_service: got=%b exp=%b", bus.service, 2'b00); end
        bus.joystick = '0;
        bus.ps2_key  = {1'b1, 1'b1, 1'b0, 8'h14};
        @(negedge clk);
        rst_n = 1'b1;
        step(4);
        checks++; if (bus.player !== 20'h0) begin failures++; $display("FAIL post_rst_player: got=%h exp=%h", bus.player, 20'h0); end
        checks++; if (bus.service !== 2'b00) begin failures++; $display("FAIL post_rst_service: got=%b exp=%b", bus.service, 2'b00); end
    endtask

    task automatic test_wide();
        logic [51:0] exp4;
        bus4.joystick[105] = 1'b1;
        step(1);
        exp4 = '0;
        exp4[48] = 1'b1;
        checks++; if (bus4.player !== exp4) begin failures++; $display("FAIL p4_fire6: got=%h exp=%h", bus4.player, exp4); end
        bus4.joystick = '0;
        send_key4(1'b1, 1'b0, 8'h1C);
        step(1);
        checks++; if (bus4.player !== 52'h0) begin failures++; $display("FAIL wide_lat1: got=%h exp=%h", bus4.player, 52'h0); end
        step(1);
        exp4 = '0;
        exp4[17] = 1'b1;
        checks++; if (bus4.player !== exp4) begin failures++; $display("FAIL wide_p2_fire1: got=%h exp=%h", bus4.player, exp4); end
        send_key4(1'b0, 1'b0, 8'h1C);
        step(1);
        send_key4(1'b1, 1'b0, 8'h16);
        step(2);
        exp4 = '0;
        exp4[10] = 1'b1;
        checks++; if (bus4.player !== exp4) begin failures++; $display("FAIL wide_p1_start: got=%h exp=%h", bus4.player, exp4); end
    endtask

    initial begin
        rst_n            = 1'b1;
        bus.ps2_key      = {1'b1, 1'b1, 1'b1, 8'h75};
        bus.joystick     = '0;
        bus.autofire_en  = '0;
        bus.clear        = 1'b0;
        bus4.ps2_key     = '0;
        bus4.joystick    = '0;
        bus4.autofire_en = '0;
        bus4.clear       = 1'b0;
        #1 rst_n = 1'b0;
        test_reset();
        test_ext_key();
        test_merge();
        test_coin();
        test_clear();
        test_autofire();
        test_reset_mid();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/input_ctrl.md
INPUT_CTRL -- requirements
Module: input_ctrl

Interface
REQ-001 SHALL have parameter PLAYERS, default 2, number of player ports (1-4).
REQ-002 SHALL have parameter BUTTONS, default 3, fire buttons per player (1-8).
REQ-003 SHALL have parameter COIN_CYCLES, default 16, coin pulse length in clk cycles (>=1).
REQ-004 SHALL have parameter AF_PERIOD, default 4, autofire half-period in clk cycles (>=1).
REQ-005 SHALL have port clk  in  1  system clock; all logic in this single domain.
REQ-006 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port ps2_key  in  11  [10] toggle, [9] pressed, [8] extended, [7:0] scancode.
REQ-008 SHALL have port joystick  in  32*PLAYERS  per-player slice: [0]R [1]L [2]D [3]U [4+:BUTTONS] fire, [4+B] start, [5+B] coin, [6+B] pause.
REQ-009 SHALL have port autofire_en  in  PLAYERS*BUTTONS  per-button autofire enable.
REQ-010 SHALL have port clear  in  1  clears all latched key states (OSD open).
REQ-011 SHALL have port player  out  (BUTTONS+7)*PLAYERS  merged controls, same bit layout as joystick slice.
REQ-012 SHALL have port service  out  2  service1/service2.

Function
REQ-013 SHALL register ps2_key[10] each cycle; a key event is ps2_key[10] != registered copy.
REQ-014 On a key event SHALL set the matching key latch to ps2_key[9]; unmapped codes are ignored.
REQ-015 Key map P1: U/D/L/R = E0 75/72/6B/74 (extended bit required); fire1/2/3 = 14/11/29 (extended ignored); start 16; coin 2E; pause 4D.
REQ-016 Key map P2: U/D/L/R = 2D/2B/23/34; fire1/2/3 = 1C/1B/15; start 1E; coin 36; service1 46; service2 45 (all non-extended only).
REQ-017 Non-extended 75/72/6B/74 (numpad) SHALL NOT drive P1 directions.
REQ-018 Keys for fire buttons > 3 or players > 2 SHALL NOT exist; those bits come from joystick only; P2 key latches are unused when PLAYERS=1.
REQ-019 Merged bit = key latch OR joystick bit; all outputs SHALL be registered.
REQ-020 Latency: joystick change -> player output 1 cycle; key event -> player output 2 cycles.
REQ-021 clear SHALL zero all key latches on the next edge; clear and key event in the same cycle: clear wins, event is consumed (toggle copy still updated).
REQ-022 Coin: on rising edge of merged coin, output coin SHALL be 1 for exactly COIN_CYCLES cycles, then 0 until the next rising edge; rising edges during an active pulse SHALL be ignored; holding coin SHALL NOT extend the pulse.
REQ-023 Autofire: free-running counter 0..AF_PERIOD-1; af_phase toggles on wrap; af_phase is 1 after reset.
REQ-024 Autofire-enabled button output = merged button AND af_phase; disabled buttons pass the merged value.
REQ-025 Counter widths SHALL be $clog2 of their range (minimum 1 bit); no overflow beyond the defined wrap.

Reset
REQ-026 rst_n low SHALL asynchronously clear key latches, toggle copy, coin counters, autofire counter, player and service to 0, and set af_phase to 1.
REQ-027 After rst_n deasserts, the first ps2_key[10] value SHALL be captured without generating an event.
REQ-028 Reset during an active coin pulse SHALL terminate the pulse immediately.

Verification
REQ-029 ps2_key toggles with {pressed=1, ext=1, 0x75} -> P1 up = 1 two cycles later; repeat with ext=0 -> P1 up stays 0.
REQ-030 joystick P1 coin high for 40 cycles, COIN_CYCLES=16 -> coin high exactly 16 cycles, one pulse; second edge at cycle 8 of a pulse -> no extension.
REQ-031 autofire_en[0]=1, AF_PERIOD=4, P1 fire1 held 32 cycles -> output 4 high / 4 low repeating, starting high.
REQ-032 key 0x29 pressed, then clear asserted together with a release event for 0x14 -> all latches 0, fire3 drops 2 cycles after clear.
REQ-033 PLAYERS=4, BUTTONS=6: joystick P4 fire6 -> only bit (6+7)*3+4+5 set; key 0x1C -> P2 fire1.
REQ-034 rst_n pulsed low mid-pulse and with keys held -> all outputs 0 asynchronously; no spurious key event after release.
